// File: rtl/fetch_queue_if.sv
// Bundle of the IF-side push port and ID-side head port of the fetch queue.
// The producer/consumer side uses the master modport and the queue uses the slave modport.
interface fetch_queue_if #(
    parameter int PC_W   = 16,
    parameter int INST_W = 16,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              if_valid;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;
    logic              id_stall;
    logic              flush;
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [INST_W-1:0] id_inst;
    logic [CNT_W-1:0]  count;

    modport master (
        output if_valid, if_pc, if_inst, id_stall, flush,
        input  if_ready, id_valid, id_pc, id_inst, count
    );

    modport slave (
        input  if_valid, if_pc, if_inst, id_stall, flush,
        output if_ready, id_valid, id_pc, id_inst, count
    );
endinterface

// File: rtl/fetch_queue.sv
// IF/ID boundary queue: DEPTH-entry in-order buffer of (pc, inst) pairs with flush.
// The head entry is presented combinationally from registered state; empty shows a bubble.
module fetch_queue #(
    parameter int                PC_W     = 16,
    parameter int                INST_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [INST_W-1:0] NOP_INST = 16'h0800
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count_q;
    logic              ready;
    logic              valid;
    logic              push;
    logic              pop;

    // Handshake: a word moves IF->queue on a clk edge when if_valid & if_ready, and
    // queue->ID when id_valid & ~id_stall; if_ready depends on registered count only.
    assign ready = (count_q < CW'(DEPTH));
    assign valid = (count_q != '0);
    assign push  = bus.if_valid & ready;
    assign pop   = valid & ~bus.id_stall;

    assign bus.if_ready = ready;
    assign bus.id_valid = valid;
    assign bus.id_pc    = valid ? pc_mem[rd_ptr]   : '0;
    assign bus.id_inst  = valid ? inst_mem[rd_ptr] : NOP_INST;
    assign bus.count    = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is left uncleared; entries beyond count are never presented.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            pc_mem[wr_ptr]   <= bus.if_pc;
            inst_mem[wr_ptr] <= bus.if_inst;
        end
    end
endmodule
